alu_operand_stage: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the ALU in the pipelined 16-bit core.
- Captures decoded instructions and resolves operand forwarding from EX, MEM and WB.
- Detects load-use hazards and stalls for one cycle when one occurs.
- Drives registered a/b/alu_control into the ALU, using a valid/ready handshake on both sides.

---
 rtl/core_pkg.sv | 26 ++
 rtl/alu_operand_stage_if.sv | 67 ++++++
 rtl/forward_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 118 +++++++++++
 tb/tb_alu_operand_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core pipeline.
// Widths, ALU op codes and the ID/EX bundle.
package core_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] alu_control;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, forwarding-source and ALU-side signals of the ID/EX stage.
// slave is the stage itself; master is whatever surrounds it.
interface alu_operand_stage_if;
    import core_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic              in_uses_rs1;
    logic              in_uses_rs2;
    logic [CTRL_W-1:0] in_alu_control;
    logic              in_reg_write;
    logic              in_mem_read;
    logic              in_mem_write;

    logic [DATA_W-1:0] alu_result;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CTRL_W-1:0] alu_control;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [DATA_W-1:0] out_store_data;
    logic [15:0]       stall_count;

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd,
        input  in_rs1_data, in_rs2_data, in_imm, in_use_imm,
        input  in_uses_rs1, in_uses_rs2, in_alu_control,
        input  in_reg_write, in_mem_read, in_mem_write,
        input  alu_result, mem_reg_write, mem_rd, mem_result,
        input  wb_reg_write, wb_rd, wb_result, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control,
        output out_rd, out_reg_write, out_mem_read, out_mem_write,
        output out_store_data, stall_count
    );

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd,
        output in_rs1_data, in_rs2_data, in_imm, in_use_imm,
        output in_uses_rs1, in_uses_rs2, in_alu_control,
        output in_reg_write, in_mem_read, in_mem_write,
        output alu_result, mem_reg_write, mem_rd, mem_result,
        output wb_reg_write, wb_rd, wb_result, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control,
        input  out_rd, out_reg_write, out_mem_read, out_mem_write,
        input  out_store_data, stall_count
    );

endinterface

// File: rtl/forward_mux.sv
// Priority operand select: EX, then MEM, then WB, then register file.
// Register 0 never forwards and always reads as zero.
module forward_mux
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    logic rs_nz;

    always_comb begin
        rs_nz = (rs != '0);
        data  = '0;
        if (ex_en && ex_rd == rs && rs_nz) begin
            data = ex_data;
        end else if (mem_en && mem_rd == rs && rs_nz) begin
            data = mem_data;
        end else if (wb_en && wb_rd == rs && rs_nz) begin
            data = wb_data;
        end else if (rs_nz) begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: operand forwarding,
// load-use stall detection and valid/ready on both sides.
module alu_operand_stage
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_operand_stage_if.slave bus
);

    id_ex_t      out_q, out_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_q, stall_d;

    logic              hazard;
    logic              in_ready;
    logic              capture;
    logic              out_fire;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              ex_fwd_en;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    // A held load has no value yet, so it is never an EX source.
    assign ex_fwd_en = valid_q & out_q.reg_write & ~out_q.mem_read;

    forward_mux u_fwd_rs1 (
        .rs       (bus.in_rs1),
        .rf_data  (bus.in_rs1_data),
        .ex_en    (ex_fwd_en),
        .ex_rd    (out_q.rd),
        .ex_data  (bus.alu_result),
        .mem_en   (bus.mem_reg_write),
        .mem_rd   (bus.mem_rd),
        .mem_data (bus.mem_result),
        .wb_en    (bus.wb_reg_write),
        .wb_rd    (bus.wb_rd),
        .wb_data  (bus.wb_result),
        .data     (fwd_rs1)
    );

    forward_mux u_fwd_rs2 (
        .rs       (bus.in_rs2),
        .rf_data  (bus.in_rs2_data),
        .ex_en    (ex_fwd_en),
        .ex_rd    (out_q.rd),
        .ex_data  (bus.alu_result),
        .mem_en   (bus.mem_reg_write),
        .mem_rd   (bus.mem_rd),
        .mem_data (bus.mem_result),
        .wb_en    (bus.wb_reg_write),
        .wb_rd    (bus.wb_rd),
        .wb_data  (bus.wb_result),
        .data     (fwd_rs2)
    );

    always_comb begin
        rs1_hit  = bus.in_uses_rs1 && (bus.in_rs1 == out_q.rd);
        rs2_hit  = bus.in_uses_rs2 && (bus.in_rs2 == out_q.rd);
        hazard   = bus.in_valid & valid_q & out_q.mem_read
                 & out_q.reg_write & (out_q.rd != '0)
                 & (rs1_hit | rs2_hit);
        out_fire = valid_q & bus.out_ready;
        in_ready = ~bus.flush & ~hazard & (~valid_q | bus.out_ready);
        capture  = bus.in_valid & in_ready;
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d           = 1'b1;
            out_d.a           = fwd_rs1;
            out_d.b           = bus.in_use_imm ? bus.in_imm : fwd_rs2;
            out_d.store_data  = fwd_rs2;
            out_d.rd          = bus.in_rd;
            out_d.alu_control = bus.in_alu_control;
            out_d.reg_write   = bus.in_reg_write;
            out_d.mem_read    = bus.in_mem_read;
            out_d.mem_write   = bus.in_mem_write;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
        // Counts regardless of flush; saturates rather than wraps.
        stall_d = stall_q;
        if (hazard && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = valid_q;
    assign bus.alu_a          = out_q.a;
    assign bus.alu_b          = out_q.b;
    assign bus.alu_control    = out_q.alu_control;
    assign bus.out_rd         = out_q.rd;
    assign bus.out_reg_write  = out_q.reg_write;
    assign bus.out_mem_read   = out_q.mem_read;
    assign bus.out_mem_write  = out_q.mem_write;
    assign bus.out_store_data = out_q.store_data;
    assign bus.stall_count    = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding, load-use stall,
// backpressure, flush and reset.
module tb_alu_operand_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] rs1, input logic [15:0] d1,
                         input logic [3:0] rs2, input logic [15:0] d2,
                         input logic [3:0] rd, input logic [2:0] op);
        bus.in_valid       = 1'b1;
        bus.in_rs1         = rs1;
        bus.in_rs1_data    = d1;
        bus.in_rs2         = rs2;
        bus.in_rs2_data    = d2;
        bus.in_rd          = rd;
        bus.in_alu_control = op;
        bus.in_uses_rs1    = 1'b1;
        bus.in_uses_rs2    = 1'b1;
        bus.in_use_imm     = 1'b0;
        bus.in_imm         = '0;
        bus.in_reg_write   = 1'b1;
        bus.in_mem_read    = 1'b0;
        bus.in_mem_write   = 1'b0;
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
        bus.in_use_imm = 0; bus.in_uses_rs1 = 0; bus.in_uses_rs2 = 0;
        bus.in_alu_control = 0; bus.in_reg_write = 0;
        bus.in_mem_read = 0; bus.in_mem_write = 0;
        bus.alu_result = 0; bus.mem_reg_write = 0; bus.mem_rd = 0;
        bus.mem_result = 0; bus.wb_reg_write = 0; bus.wb_rd = 0;
        bus.wb_result = 0;

        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        chk("rst_ctrl", bus.alu_control, 0);
        chk("rst_rd", bus.out_rd, 0);
        chk("rst_ctl_bits", {bus.out_reg_write, bus.out_mem_read,
                             bus.out_mem_write}, 0);
        chk("rst_store", bus.out_store_data, 0);
        chk("rst_stall", bus.stall_count, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // ADD r1 = r2 + r3
        bus.out_ready = 1'b1;
        instr(4'd2, 16'h0001, 4'd3, 16'h0004, 4'd1, ALU_ADD);
        tick();
        chk("add_valid", bus.out_valid, 1);
        chk("add_a", bus.alu_a, 16'h0001);
        chk("add_rd", bus.out_rd, 1);

        // SUB r2 = r1 - r3 picks up r1 from EX
        instr(4'd1, 16'h0000, 4'd3, 16'h0004, 4'd2, ALU_SUB);
        bus.alu_result = 16'h0005;
        #1;
        chk("sub_in_ready", bus.in_ready, 1);
        tick();
        chk("ex_fwd_a", bus.alu_a, 16'h0005);
        chk("ex_fwd_b", bus.alu_b, 16'h0004);
        chk("ex_fwd_ctrl", bus.alu_control, ALU_SUB);

        // MEM beats WB; r0 stays zero
        instr(4'd4, 16'h0011, 4'd0, 16'h0077, 4'd6, ALU_AND);
        bus.mem_reg_write = 1; bus.mem_rd = 4; bus.mem_result = 16'h00AA;
        bus.wb_reg_write = 1; bus.wb_rd = 4; bus.wb_result = 16'h00BB;
        tick();
        chk("mem_over_wb", bus.alu_a, 16'h00AA);
        chk("r0_rs2_zero", bus.alu_b, 16'h0000);

        instr(4'd0, 16'h5555, 4'd4, 16'h0099, 4'd6, ALU_OR);
        bus.in_use_imm = 1; bus.in_imm = 16'h00F0;
        bus.mem_reg_write = 0;
        bus.wb_rd = 0; bus.wb_result = 16'h1234;
        tick();
        chk("r0_no_wb_fwd", bus.alu_a, 16'h0000);
        chk("imm_b", bus.alu_b, 16'h00F0);
        chk("store_rf", bus.out_store_data, 16'h0099);

        // LW r5, 8(r0)
        instr(4'd0, 16'h0000, 4'd0, 16'h0000, 4'd5, ALU_ADD);
        bus.wb_reg_write = 0;
        bus.in_uses_rs2 = 0; bus.in_use_imm = 1; bus.in_imm = 16'h0008;
        bus.in_mem_read = 1;
        tick();
        chk("load_held", {bus.out_valid, bus.out_mem_read}, 2'b11);

        // ADD r7 = r6 + r5 must wait one cycle
        instr(4'd6, 16'h0003, 4'd5, 16'hDEAD, 4'd7, ALU_ADD);
        #1;
        chk("lu_in_ready", bus.in_ready, 0);
        tick();
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_stall_cnt", bus.stall_count, 1);
        bus.mem_reg_write = 1; bus.mem_rd = 5; bus.mem_result = 16'h0042;
        #1;
        chk("lu_retry_ready", bus.in_ready, 1);
        tick();
        chk("lu_valid", bus.out_valid, 1);
        chk("lu_mem_fwd_b", bus.alu_b, 16'h0042);
        chk("lu_a", bus.alu_a, 16'h0003);
        chk("lu_stall_once", bus.stall_count, 1);

        // Backpressure: held ADD r7 must not move
        bus.out_ready = 0;
        bus.mem_reg_write = 0;
        instr(4'd8, 16'h0010, 4'd9, 16'h0020, 4'd10, ALU_SLT);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            tick();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_a", bus.alu_a, 16'h0003);
            chk("bp_b", bus.alu_b, 16'h0042);
            chk("bp_rd", bus.out_rd, 7);
        end
        bus.out_ready = 1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        tick();
        chk("bp_next_a", bus.alu_a, 16'h0010);
        chk("bp_next_b", bus.alu_b, 16'h0020);
        chk("bp_next_rd", bus.out_rd, 10);
        bus.in_valid = 0;
        tick();
        chk("bp_no_dup", bus.out_valid, 0);

        // Flush kills held and incoming
        instr(4'd1, 16'h0001, 4'd2, 16'h0002, 4'd11, ALU_ADD);
        tick();
        chk("fl_held", bus.out_valid, 1);
        instr(4'd1, 16'h0001, 4'd2, 16'h0002, 4'd12, ALU_ADD);
        bus.flush = 1;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        tick();
        chk("fl_killed", bus.out_valid, 0);
        bus.flush = 0; bus.in_valid = 0;
        tick();
        chk("fl_not_captured", bus.out_valid, 0);

        // Flush during hazard still counts the stall
        instr(4'd0, 16'h0000, 4'd0, 16'h0000, 4'd5, ALU_ADD);
        bus.in_uses_rs2 = 0; bus.in_use_imm = 1; bus.in_mem_read = 1;
        tick();
        instr(4'd5, 16'h0000, 4'd0, 16'h0000, 4'd7, ALU_ADD);
        bus.flush = 1;
        tick();
        chk("flhz_valid", bus.out_valid, 0);
        chk("flhz_stall_cnt", bus.stall_count, 2);
        bus.flush = 0;

        // Reset in the middle of a stall
        instr(4'd0, 16'h0000, 4'd0, 16'h0000, 4'd5, ALU_ADD);
        bus.in_uses_rs2 = 0; bus.in_use_imm = 1; bus.in_mem_read = 1;
        bus.out_ready = 0;
        tick();
        instr(4'd5, 16'h0000, 4'd0, 16'h0000, 4'd7, ALU_ADD);
        #1;
        chk("rs_hazard_ready", bus.in_ready, 0);
        rst = 1;
        #1;
        chk("rs_valid", bus.out_valid, 0);
        chk("rs_stall_cnt", bus.stall_count, 0);
        bus.in_valid = 0;
        tick();
        rst = 0;
        #1;
        chk("rs_empty_ready", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
